register_bank: RTL and testbench
================================

# register_bank

Parametrised successor to the MIPS general-purpose register file. It provides N_READ asynchronous read ports and one synchronous write port, with register 0 hardwired to zero. A per-register pending scoreboard lets the decode stage detect read-after-write hazards. After reset, a sweep state machine clears every register one per cycle, so the array can map to distributed RAM. It sits between the decode stage (reads, reservations) and the write-back stage (writes).

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers
- N_READ, 2, number of read ports (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rd_address  in  N_READ*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  N_READ*DATA_WIDTH  read data, same packing
- rd_pending  out  N_READ  port i address has an outstanding reservation
- wr_address  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- reg_write  in  1  write enable
- rsv_valid  in  1  reserve (mark pending) rsv_address
- rsv_address  in  ADDR_WIDTH  destination being issued
- ready  out  1  clear sweep finished, block accepts traffic

## Operation
- States: CLEAR, RUN.
- While reset=1: state=CLEAR, sweep counter=0, all pending bits=0, ready=0.
- CLEAR, reset=0: each edge writes 0 to reg[counter] and increments counter. When counter==DEPTH-1 is cleared, go to RUN.
- RUN only changes on reset.
- In CLEAR, reg_write and rsv_valid are ignored. rd_data reads 0 and rd_pending reads 0 on all ports.
- RUN write: on the edge with reg_write=1 and wr_address≠0, reg[wr_address] ← wr_data, and pending[wr_address] is cleared.
- RUN reserve: on the edge with rsv_valid=1 and rsv_address≠0, pending[rsv_address] is set.
- Same edge, same address, reserve and write: set wins, because a new producer supersedes the old one.
- Reads are combinational: rd_data[i] = reg[addr_i], and always 0 when addr_i=0. rd_pending[i] = pending[addr_i], and always 0 for address 0.
- Writes and reserves to address 0 have no effect. Register 0 is never stored as nonzero.
- Any number of read ports may present the same address.
- Reset asserted mid-sweep or in RUN: return to CLEAR with counter 0 on that edge, and restart the full sweep.

## Timing
- Read latency 0 (combinational from address and state). Write and reserve take effect at the next rising edge.
- Reset values: ready=0, rd_data=0, rd_pending=0.
- ready rises after exactly DEPTH rising edges with reset=0. For DEPTH=32, ready is high after the 32nd such edge.
- The first write is accepted on the first edge where ready=1 at the preceding cycle.
- Sweep counter is ADDR_WIDTH bits wide. The terminal compare is against DEPTH-1; wrap-around is not relied on.

## Configuration
- REGISTER_BYPASS_EN defined:
  - In RUN, for each port i: if reg_write=1, wr_address≠0 and wr_address==addr_i, then rd_data[i]=wr_data.
  - Also, rd_pending[i] reads 0 unless rsv_valid=1 with rsv_address==addr_i in the same cycle.
  - This gives write-through forwarding for a same-cycle write-back.
- REGISTER_BYPASS_EN undefined: rd_data and rd_pending show pre-edge stored values. A same-cycle write is visible only from the next cycle.

## Structure
- Shared package register_bank_pkg holds:
  - defaults REG_DATA_WIDTH=32, REG_ADDR_WIDTH=5, REG_N_READ=2;
  - the state enumeration {ST_CLEAR, ST_RUN}.
- Sub-module register_bank_clear_fsm holds the sweep counter, state and ready. It outputs clear_en and clear_address to the array.
- The array, pending vector and read muxes stay in register_bank.

## Test plan
- Reset held 3 cycles, then released: ready=0 for 32 edges, then 1. During the sweep, reg_write to address 4 with data 0xDEAD is ignored; a later read of address 4 returns 0.
- RUN: write 0x12345678 to r7; next cycle, port 0 reads r7 and port 1 reads r7. Both return 0x12345678. A write of 0xFFFFFFFF to r0 still reads 0.
- Reserve r9. Next cycle rd_pending=1 for a port on r9. Write r9=0x55: pending=0 from the following cycle. Reserve and write r9 on the same edge: pending stays 1.
- Same-cycle write of 0xA5A5A5A5 to r3 while reading r3:
  - with REGISTER_BYPASS_EN, rd_data=0xA5A5A5A5 that cycle;
  - without it, the old value that cycle and 0xA5A5A5A5 the next.
- Assert reset at sweep count 10: ready stays 0, and a further 32 reset-free edges are needed. All registers previously written read 0.
- N_READ=3, ADDR_WIDTH=3, DATA_WIDTH=16: ready after 8 edges, and three independent reads of r1, r2, r5 return 0x0001, 0x0002, 0x0005 after those writes.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared definitions for the register_bank slice: default geometry and the
// clear-sweep state encoding used by register_bank_clear_fsm.
package register_bank_pkg;

   localparam int REG_DATA_WIDTH = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int REG_N_READ     = 2;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/register_bank_clear_fsm.sv
// Post-reset clear sequencer for register_bank. Walks every register address
// once, one per cycle, so the array itself needs no reset and can map to
// distributed RAM. ready goes high once the last address has been cleared.
module register_bank_clear_fsm
   import register_bank_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  clear_en,
   output logic [ADDR_WIDTH-1:0] clear_address,
   output logic                  ready
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;
   logic                  ready_q, ready_d;

   // Next-state logic: advance the sweep counter until the last register is cleared.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ready_d = ready_q;
      case (state_q)
         ST_CLEAR: begin
            if (count_q == LAST_ADDR) begin
               state_d = ST_RUN;
               count_d = {ADDR_WIDTH{1'b0}};
               ready_d = 1'b1;
            end else begin
               count_d = count_q + ADDR_WIDTH'(1'b1);
               ready_d = 1'b0;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
            ready_d = 1'b1;
         end
         default: begin
            state_d = ST_CLEAR;
            count_d = {ADDR_WIDTH{1'b0}};
            ready_d = 1'b0;
         end
      endcase
   end

   // State, counter and ready registers with synchronous reset back to a fresh sweep.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         count_q <= {ADDR_WIDTH{1'b0}};
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ready_q <= ready_d;
      end
   end

   assign clear_en      = (state_q == ST_CLEAR) && !reset;
   assign clear_address = count_q;
   assign ready         = ready_q;

endmodule

// File: rtl/register_bank.sv
// Register file with N_READ combinational read ports, one write-back port,
// register 0 hardwired to zero and a per-register pending scoreboard for
// read-after-write hazard detection in decode.
// Optional feature: define REGISTER_BYPASS_EN for same-cycle write-through
// forwarding of write-back data (and scoreboard state) to the read ports.
module register_bank
   import register_bank_pkg::*;
#(
   parameter int DATA_WIDTH = REG_DATA_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
   parameter int N_READ     = REG_N_READ
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_READ*ADDR_WIDTH-1:0] rd_address,
   output logic [N_READ*DATA_WIDTH-1:0] rd_data,
   output logic [N_READ-1:0]            rd_pending,
   input  logic [ADDR_WIDTH-1:0]        wr_address,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         reg_write,
   input  logic                         rsv_valid,
   input  logic [ADDR_WIDTH-1:0]        rsv_address,
   output logic                         ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]      pend_q, pend_d;
   logic                  clear_en_s;
   logic [ADDR_WIDTH-1:0] clear_address_s;
   logic                  ready_s;
   logic                  wr_en_s;
   logic                  rsv_en_s;

   register_bank_clear_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_fsm (
      .clk           (clk),
      .reset         (reset),
      .clear_en      (clear_en_s),
      .clear_address (clear_address_s),
      .ready         (ready_s)
   );

   assign ready = ready_s;

   // Writes/reserves are honoured only in RUN, never during a reset edge, never to r0.
   assign wr_en_s  = ready_s && !reset && reg_write && (wr_address != {ADDR_WIDTH{1'b0}});
   assign rsv_en_s = ready_s && !reset && rsv_valid && (rsv_address != {ADDR_WIDTH{1'b0}});

   // Storage array: sweep clears during CLEAR, write-back port during RUN.
   always_ff @(posedge clk) begin
      if (clear_en_s) begin
         mem_q[clear_address_s] <= {DATA_WIDTH{1'b0}};
      end else if (wr_en_s) begin
         mem_q[wr_address] <= wr_data;
      end
   end

   // Scoreboard next state: write clears, reserve sets afterwards so a new producer wins.
   always_comb begin
      pend_d = pend_q;
      if (ready_s) begin
         if (wr_en_s) begin
            pend_d[wr_address] = 1'b0;
         end else begin
            pend_d = pend_d;
         end
         if (rsv_en_s) begin
            pend_d[rsv_address] = 1'b1;
         end else begin
            pend_d = pend_d;
         end
      end else begin
         pend_d = {DEPTH{1'b0}};
      end
      pend_d[0] = 1'b0;
   end

   // Scoreboard register, cleared by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= {DEPTH{1'b0}};
      end else begin
         pend_q <= pend_d;
      end
   end

   // Combinational read muxes; r0 and the CLEAR phase always read as zero.
   always_comb begin
      rd_data    = {(N_READ*DATA_WIDTH){1'b0}};
      rd_pending = {N_READ{1'b0}};
      for (int i = 0; i < N_READ; i++) begin
         if (ready_s && (rd_address[i*ADDR_WIDTH +: ADDR_WIDTH] != {ADDR_WIDTH{1'b0}})) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_address[i*ADDR_WIDTH +: ADDR_WIDTH]];
            rd_pending[i] = pend_q[rd_address[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGISTER_BYPASS_EN
            if (wr_en_s && (wr_address == rd_address[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
               rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
               rd_pending[i] = rsv_en_s && (rsv_address == rd_address[i*ADDR_WIDTH +: ADDR_WIDTH]);
            end else begin
               rd_pending[i] = rd_pending[i];
            end
`endif
         end else begin
            rd_pending[i] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: default geometry (32x32, 2 read
// ports) plus a small instance (8x16, 3 read ports). Honours
// REGISTER_BYPASS_EN when selecting same-cycle expected values.
module tb_register_bank;

`ifdef REGISTER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Default-geometry instance signals
   logic [9:0]  rd_address_a;
   logic [63:0] rd_data_a;
   logic [1:0]  rd_pending_a;
   logic [4:0]  wr_address_a;
   logic [31:0] wr_data_a;
   logic        reg_write_a;
   logic        rsv_valid_a;
   logic [4:0]  rsv_address_a;
   logic        ready_a;

   // Small instance signals
   logic [8:0]  rd_address_b;
   logic [47:0] rd_data_b;
   logic [2:0]  rd_pending_b;
   logic [2:0]  wr_address_b;
   logic [15:0] wr_data_b;
   logic        reg_write_b;
   logic        rsv_valid_b;
   logic [2:0]  rsv_address_b;
   logic        ready_b;

   register_bank dut_a (
      .clk (clk), .reset (reset),
      .rd_address (rd_address_a), .rd_data (rd_data_a), .rd_pending (rd_pending_a),
      .wr_address (wr_address_a), .wr_data (wr_data_a), .reg_write (reg_write_a),
      .rsv_valid (rsv_valid_a), .rsv_address (rsv_address_a), .ready (ready_a)
   );

   register_bank #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .N_READ(3)) dut_b (
      .clk (clk), .reset (reset),
      .rd_address (rd_address_b), .rd_data (rd_data_b), .rd_pending (rd_pending_b),
      .wr_address (wr_address_b), .wr_data (wr_data_b), .reg_write (reg_write_b),
      .rsv_valid (rsv_valid_b), .rsv_address (rsv_address_b), .ready (ready_b)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic [4:0]  ra;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        p0;
      logic        p1;
   } vec_t;

   vec_t tbl [15];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic re, input logic [4:0] ra,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic p0, input logic p1);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
      v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.p0 = p0; v.p1 = p1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      reg_write_a = 1'b0; wr_address_a = 5'd0; wr_data_a = 32'd0;
      rsv_valid_a = 1'b0; rsv_address_a = 5'd0;
   endtask

   initial begin
      // Stimulus table for the RUN phase of the default instance
      tbl[0]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd4, 32'h0, 32'h0, 1'b0, 1'b0);
      tbl[1]  = mk(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd7, 5'd7,
                   BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0, 1'b0, 1'b0);
      tbl[2]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 1'b0, 1'b0);
      tbl[3]  = mk(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h12345678, 1'b0, 1'b0);
      tbl[4]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      tbl[5]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      tbl[6]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h0, 32'h0, 1'b1, 1'b1);
      tbl[7]  = mk(1'b1, 5'd9, 32'h55,       1'b0, 5'd0, 5'd9, 5'd1,
                   BYP ? 32'h55 : 32'h0, 32'h0, BYP ? 1'b0 : 1'b1, 1'b0);
      tbl[8]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h55, 32'h55, 1'b0, 1'b0);
      tbl[9]  = mk(1'b1, 5'd9, 32'h77,       1'b1, 5'd9, 5'd9, 5'd9,
                   BYP ? 32'h77 : 32'h55, BYP ? 32'h77 : 32'h55, BYP, BYP);
      tbl[10] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h77, 32'h77, 1'b1, 1'b1);
      tbl[11] = mk(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd9,
                   BYP ? 32'hA5A5A5A5 : 32'h0, 32'h77, 1'b0, 1'b1);
      tbl[12] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0);
      tbl[13] = mk(1'b1, 5'd4, 32'h11,       1'b1, 5'd0, 5'd0, 5'd4, 32'h0, BYP ? 32'h11 : 32'h0, 1'b0, 1'b0);
      tbl[14] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd4, 32'h0, 32'h11, 1'b0, 1'b0);

      reset = 1'b1;
      idle_a();
      rd_address_a = {5'd7, 5'd0};
      reg_write_b = 1'b0; wr_address_b = 3'd0; wr_data_b = 16'd0;
      rsv_valid_b = 1'b0; rsv_address_b = 3'd0;
      rd_address_b = {3'd5, 3'd2, 3'd1};

      // Reset held for three edges
      repeat (3) step();
      #2;
      chk("reset_ready_a", {31'd0, ready_a}, 32'd0);
      chk("reset_ready_b", {31'd0, ready_b}, 32'd0);
      chk("reset_rd_data_a", rd_data_a[63:32], 32'd0);
      chk("reset_rd_pending_a", {30'd0, rd_pending_a}, 32'd0);
      chk("reset_rd_data_b", rd_data_b[31:0], 32'd0);

      // Clear sweep: count edges, try an ignored write at sweep step 5
      reset = 1'b0;
      rd_address_a = {5'd4, 5'd4};
      for (int k = 0; k < 32; k++) begin
         if (k == 5) begin
            reg_write_a = 1'b1; wr_address_a = 5'd4; wr_data_a = 32'hDEAD;
            rsv_valid_a = 1'b1; rsv_address_a = 5'd4;
         end else begin
            idle_a();
         end
         #2;
         chk($sformatf("sweep_ready_a_%0d", k), {31'd0, ready_a}, 32'd0);
         chk($sformatf("sweep_ready_b_%0d", k), {31'd0, ready_b}, (k >= 8) ? 32'd1 : 32'd0);
         if (k == 5) chk("sweep_rd_data_a", rd_data_a[31:0], 32'd0);
         step();
      end
      idle_a();
      #2;
      chk("sweep_done_ready_a", {31'd0, ready_a}, 32'd1);

      // Table-driven RUN vectors; outputs compared before the applying edge
      for (int i = 0; i < 15; i++) begin
         reg_write_a   = tbl[i].we;
         wr_address_a  = tbl[i].wa;
         wr_data_a     = tbl[i].wd;
         rsv_valid_a   = tbl[i].re;
         rsv_address_a = tbl[i].ra;
         rd_address_a  = {tbl[i].a1, tbl[i].a0};
         #2;
         chk($sformatf("vec%0d_rd_data0", i), rd_data_a[31:0], tbl[i].d0);
         chk($sformatf("vec%0d_rd_data1", i), rd_data_a[63:32], tbl[i].d1);
         chk($sformatf("vec%0d_rd_pending", i), {30'd0, rd_pending_a}, {30'd0, tbl[i].p1, tbl[i].p0});
         step();
      end
      idle_a();

      // Small instance: three writes then three independent reads
      reg_write_b = 1'b1; wr_address_b = 3'd1; wr_data_b = 16'h0001; step();
      wr_address_b = 3'd2; wr_data_b = 16'h0002; step();
      wr_address_b = 3'd5; wr_data_b = 16'h0005; step();
      reg_write_b = 1'b0;
      rd_address_b = {3'd5, 3'd2, 3'd1};
      #2;
      chk("b_rd_port0_r1", {16'd0, rd_data_b[15:0]},  32'h0001);
      chk("b_rd_port1_r2", {16'd0, rd_data_b[31:16]}, 32'h0002);
      chk("b_rd_port2_r5", {16'd0, rd_data_b[47:32]}, 32'h0005);
      step();

      // Reset in RUN, then again at sweep count 10: full sweep must restart
      reset = 1'b1; step();
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #2;
         chk($sformatf("first_sweep_ready_%0d", k), {31'd0, ready_a}, 32'd0);
         step();
      end
      reset = 1'b1; step();
      reset = 1'b0;
      rd_address_a = {5'd3, 5'd7};
      for (int k = 0; k < 32; k++) begin
         #2;
         chk($sformatf("resweep_ready_%0d", k), {31'd0, ready_a}, 32'd0);
         if (k == 3) chk("resweep_rd_data", rd_data_a[31:0], 32'd0);
         step();
      end
      #2;
      chk("resweep_done_ready", {31'd0, ready_a}, 32'd1);
      chk("after_reset_r7", rd_data_a[31:0], 32'd0);
      chk("after_reset_r3", rd_data_a[63:32], 32'd0);
      rd_address_a = {5'd4, 5'd9};
      #1;
      chk("after_reset_r9", rd_data_a[31:0], 32'd0);
      chk("after_reset_r4", rd_data_a[63:32], 32'd0);
      chk("after_reset_pending", {30'd0, rd_pending_a}, 32'd0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
